id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the five-stage core. Captures the decoded instruction bundle each cycle and presents ALU operands and control to the execute stage. It resolves data hazards by forwarding from EX/MEM and MEM/WB, and inserts bubbles for load-use stalls and branch flushes. Sits between the decode/register-file stage and the ALU; its `input1`, `input2`, `ex_cmd`, `ALUOp` and `branchD` drive the ALU directly.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register index width

Ports:
- `clk`  in  1  the one clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `d_valid`  in  1  decode stage holds a valid instruction
- `d_rd1`, `d_rd2`  in  DATA_W  register-file read data for rs and rt
- `d_imm`  in  DATA_W  sign-extended offset
- `d_rs`, `d_rt`, `d_rd`  in  REG_AW  source and destination indices
- `d_alu_src`  in  1  1 = immediate drives `input2`
- `d_reg_dst`  in  1  1 = destination is rd, 0 = rt
- `d_reg_write`, `d_mem_read`, `d_mem_write`, `d_mem_to_reg`  in  1  control bits
- `d_alu_op`  in  2  0 = load/store add, 1 = branch subtract, 2 = R-type
- `d_ex_cmd`  in  4  ALU function code
- `d_branch`  in  1  branch instruction
- `flush`  in  1  taken-branch redirect; kills the instruction being captured
- `m_reg_write`  in  1, `m_rd`  in  REG_AW, `m_alu_out`  in  DATA_W  EX/MEM writeback info
- `w_reg_write`  in  1, `w_rd`  in  REG_AW, `w_result`  in  DATA_W  MEM/WB writeback info
- `stall_fd`  out  1  hold PC and IF/ID register
- `input1`, `input2`  out  DATA_W  ALU operands
- `ex_cmd`  out  4, `ALUOp`  out  2, `branchD`  out  1  ALU control
- `e_valid`, `e_reg_write`, `e_mem_read`, `e_mem_write`, `e_mem_to_reg`  out  1  execute-stage control
- `e_dest`  out  REG_AW  resolved destination register
- `e_store_data`  out  DATA_W  forwarded rt value for stores
- `stall_cnt`  out  16  saturating count of stall cycles

## Operation
- Each cycle the E register loads one of three things:
  - Reset (`rst_n`=0): all fields zero.
  - Bubble: when `flush`, when `stall_fd`, or when `d_valid`=0. Bubble has `e_valid`=0, all control bits 0, `ALUOp`=0, `ex_cmd`=0, `branchD`=0. Data fields are don't-care and are held at 0.
  - Otherwise: the decode bundle.
- Priority: reset > flush > stall > capture.
- `e_dest` = `d_reg_dst` ? `d_rd` : `d_rt`, resolved at capture.
- Capture-time bypass: if `w_reg_write`, `w_rd`≠0 and `w_rd` equals `d_rs`, store `w_result` instead of `d_rd1`. The same rule applies to `d_rt` and `d_rd2`.
- rt is treated as a source when `d_alu_src`=0 or `d_mem_write`=1. rs is always a source.
- Load-use stall: `stall_fd`=1 when all of the following hold:
  - `d_valid`=1 and `flush`=0;
  - `e_valid`=1, `e_mem_read`=1 and `e_dest`≠0;
  - `e_dest` matches a source of the decode instruction.
- Forwarding (combinational, at E outputs), per operand:
  - First choice: `m_alu_out` if `m_reg_write`, `m_rd`≠0 and `m_rd` equals the E-stage source index.
  - Second choice: `w_result` under the same rule with `w_rd`.
  - Otherwise: the registered value.
  - Register 0 is never forwarded.
- Operand assignment:
  - `input1` = forwarded rs.
  - `e_store_data` = forwarded rt.
  - `input2` = `e_alu_src` ? `e_imm` : forwarded rt.
- `stall_cnt` increments on each cycle with `stall_fd`=1 and saturates at 16'hFFFF. Reset clears it to 0.

## Timing
- Capture to ALU outputs: 1 cycle. Forward paths and `stall_fd` are combinational in the same cycle.
- A load followed immediately by a dependent instruction costs exactly 1 bubble cycle.
- Reset values: every output is 0. This includes `input1`/`input2`; the stored rs/rt indices are 0, so nothing is forwarded.
- Simultaneous `flush` and a load-use condition: `stall_fd`=0 and a bubble is inserted.
- Reset asserted mid-stall: the next cycle, `e_valid`=0 and `stall_fd`=0.
- A held bundle is not required to persist: during a stall, decode re-presents the same bundle next cycle.

## Configuration
- `ID_EX_FORWARD_EN` defined: EX/MEM and MEM/WB forwarding muxes are present as specified above.
- Undefined: no forwarding muxes; operands come straight from registers (capture-time W bypass is kept). `stall_fd` additionally asserts when a decode source matches either:
  - a valid E-stage `e_reg_write` destination, or
  - `m_reg_write`/`m_rd`.
  
  Register 0 is excluded in both cases.

## Structure
- Shared package `cpu_pkg` holds:
  - the `ALUOp` encodings (`ALUOP_MEM`=0, `ALUOP_BRANCH`=1, `ALUOP_RTYPE`=2);
  - the `ex_cmd` codes (ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, MUL 4'b1111);
  - the `id_ex_t` bundle struct and its bubble constant.
- One sub-module, `fwd_sel`: the priority forwarding mux. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs. Required: every output is 0 and `stall_cnt`=0.
- R-type `add` reading r3 right after an `add` writing r3. The producer's `m_alu_out`=32'h10 is in EX/MEM, and MEM/WB writes r3=32'h5 in the same cycle. Required: `input1`=32'h10, showing EX/MEM priority.
- `lw r4` followed immediately by `sub r5,r4,r2`. Required: `stall_fd`=1 for exactly 1 cycle, one bubble with `e_valid`=0, then `input1` = `w_result` of the load.
- Branch flush during a load-use condition. Required: `stall_fd`=0, bubble inserted, `stall_cnt` unchanged.
- `sw` with `d_alu_src`=1 and `d_imm`=8, with the rt value forwarded from EX/MEM. Required: `input2`=8, `e_store_data` = forwarded value, `ALUOp`=0.
- Destination r0 writer followed by an r0 reader. Required: no forwarding and no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: ALUOp encodings, ALU function codes and the
// ID/EX bundle carried from decode into execute.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_REG_AW = 5;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'd0,
        ALUOP_BRANCH = 2'd1,
        ALUOP_RTYPE  = 2'd2
    } alu_op_e;

    localparam logic [3:0] EX_ADD = 4'b0010;
    localparam logic [3:0] EX_SUB = 4'b0110;
    localparam logic [3:0] EX_AND = 4'b0000;
    localparam logic [3:0] EX_OR  = 4'b0001;
    localparam logic [3:0] EX_MUL = 4'b1111;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic                  branch;
        alu_op_e               alu_op;
        logic [3:0]            ex_cmd;
        logic [CPU_REG_AW-1:0] rs;
        logic [CPU_REG_AW-1:0] rt;
        logic [CPU_REG_AW-1:0] dest;
        logic [CPU_DATA_W-1:0] rd1;
        logic [CPU_DATA_W-1:0] rd2;
        logic [CPU_DATA_W-1:0] imm;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    // A write to register 0 never produces a value anyone may consume.
    function automatic logic reg_hit(input logic                  en,
                                     input logic [CPU_REG_AW-1:0] wr_idx,
                                     input logic [CPU_REG_AW-1:0] rd_idx);
        return en && (wr_idx != '0) && (wr_idx == rd_idx);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority forwarding mux for one ALU operand: EX/MEM beats MEM/WB beats
// the value captured in the ID/EX register; register 0 is never forwarded.
module fwd_sel #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_reg_val,
    input  logic              i_m_reg_write,
    input  logic [REG_AW-1:0] i_m_rd,
    input  logic [DATA_W-1:0] i_m_val,
    input  logic              i_w_reg_write,
    input  logic [REG_AW-1:0] i_w_rd,
    input  logic [DATA_W-1:0] i_w_val,
    output logic [DATA_W-1:0] o_val
);

    logic w_m_hit;
    logic w_w_hit;

    assign w_m_hit = i_m_reg_write && (i_m_rd != '0) && (i_m_rd == i_src);
    assign w_w_hit = i_w_reg_write && (i_w_rd != '0) && (i_w_rd == i_src);

    always_comb begin
        o_val = i_reg_val;
        if (w_m_hit) begin
            o_val = i_m_val;
        end else if (w_w_hit) begin
            o_val = i_w_val;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch-flush bubbles and
// operand forwarding. Define ID_EX_FORWARD_EN to enable the EX/MEM and MEM/WB
// forwarding muxes; without it, dependent instructions stall instead.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_rd1,
    input  logic [DATA_W-1:0] d_rd2,
    input  logic [DATA_W-1:0] d_imm,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_alu_src,
    input  logic              d_reg_dst,
    input  logic              d_reg_write,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic              d_mem_to_reg,
    input  logic [1:0]        d_alu_op,
    input  logic [3:0]        d_ex_cmd,
    input  logic              d_branch,
    input  logic              flush,
    input  logic              m_reg_write,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [DATA_W-1:0] m_alu_out,
    input  logic              w_reg_write,
    input  logic [REG_AW-1:0] w_rd,
    input  logic [DATA_W-1:0] w_result,
    output logic              stall_fd,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [3:0]        ex_cmd,
    output logic [1:0]        ALUOp,
    output logic              branchD,
    output logic              e_valid,
    output logic              e_reg_write,
    output logic              e_mem_read,
    output logic              e_mem_write,
    output logic              e_mem_to_reg,
    output logic [REG_AW-1:0] e_dest,
    output logic [DATA_W-1:0] e_store_data,
    output logic [15:0]       stall_cnt
);

    id_ex_t            r_e;
    logic [15:0]       r_stall_cnt;
    id_ex_t            w_cap;
    logic              w_rt_src;
    logic              w_e_hit;
    logic              w_hazard;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    assign w_rt_src = ~d_alu_src | d_mem_write;
    assign w_e_hit  = reg_hit(1'b1, r_e.dest, d_rs)
                    | (w_rt_src & reg_hit(1'b1, r_e.dest, d_rt));

`ifdef ID_EX_FORWARD_EN
    assign w_hazard = r_e.valid & r_e.mem_read & w_e_hit;
`else
    logic w_m_hit;
    assign w_m_hit  = reg_hit(m_reg_write, m_rd, d_rs)
                    | (w_rt_src & reg_hit(m_reg_write, m_rd, d_rt));
    // Without forwarding, any in-flight producer not yet in WB must drain.
    assign w_hazard = (r_e.valid & (r_e.mem_read | r_e.reg_write) & w_e_hit)
                    | w_m_hit;
`endif

    // Gated by reset so a stall never leaks out while the pipe is held in reset.
    assign stall_fd = rst_n & d_valid & ~flush & w_hazard;
    assign w_bubble = flush | stall_fd | ~d_valid;

    always_comb begin
        w_cap            = ID_EX_BUBBLE;
        w_cap.valid      = 1'b1;
        w_cap.reg_write  = d_reg_write;
        w_cap.mem_read   = d_mem_read;
        w_cap.mem_write  = d_mem_write;
        w_cap.mem_to_reg = d_mem_to_reg;
        w_cap.alu_src    = d_alu_src;
        w_cap.branch     = d_branch;
        w_cap.alu_op     = alu_op_e'(d_alu_op);
        w_cap.ex_cmd     = d_ex_cmd;
        w_cap.rs         = d_rs;
        w_cap.rt         = d_rt;
        w_cap.dest       = d_reg_dst ? d_rd : d_rt;
        w_cap.rd1        = reg_hit(w_reg_write, w_rd, d_rs) ? w_result : d_rd1;
        w_cap.rd2        = reg_hit(w_reg_write, w_rd, d_rt) ? w_result : d_rd2;
        w_cap.imm        = d_imm;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e         <= ID_EX_BUBBLE;
            r_stall_cnt <= '0;
        end else begin
            r_e <= w_bubble ? ID_EX_BUBBLE : w_cap;
            if (stall_fd && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

`ifdef ID_EX_FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    // Write enables tied low: the mux collapses to the registered operand.
    localparam logic FWD_ON = 1'b0;
`endif

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_src         (r_e.rs),
        .i_reg_val     (r_e.rd1),
        .i_m_reg_write (FWD_ON & m_reg_write),
        .i_m_rd        (m_rd),
        .i_m_val       (m_alu_out),
        .i_w_reg_write (FWD_ON & w_reg_write),
        .i_w_rd        (w_rd),
        .i_w_val       (w_result),
        .o_val         (w_fwd_rs)
    );

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_src         (r_e.rt),
        .i_reg_val     (r_e.rd2),
        .i_m_reg_write (FWD_ON & m_reg_write),
        .i_m_rd        (m_rd),
        .i_m_val       (m_alu_out),
        .i_w_reg_write (FWD_ON & w_reg_write),
        .i_w_rd        (w_rd),
        .i_w_val       (w_result),
        .o_val         (w_fwd_rt)
    );

    assign input1       = w_fwd_rs;
    assign input2       = r_e.alu_src ? r_e.imm : w_fwd_rt;
    assign e_store_data = w_fwd_rt;
    assign ex_cmd       = r_e.ex_cmd;
    assign ALUOp        = r_e.alu_op;
    assign branchD      = r_e.branch;
    assign e_valid      = r_e.valid;
    assign e_reg_write  = r_e.reg_write;
    assign e_mem_read   = r_e.mem_read;
    assign e_mem_write  = r_e.mem_write;
    assign e_mem_to_reg = r_e.mem_to_reg;
    assign e_dest       = r_e.dest;
    assign stall_cnt    = r_stall_cnt;

endmodule
